// File: rtl/test_sig_pkg.sv
// Shared types and constants for the multi-channel test-signal generator.
package test_sig_pkg;

    // Per-channel run state; encoding is exposed on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_t;

    // Power-up waveform: 3125 Hz square wave from a 100 MHz sysclk.
    localparam int DEF_PERIOD = 32000;
    localparam int DEF_HIGH   = 16000;

    // Shortest usable period; smaller programmed values are clamped to this.
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/test_sig_chan.sv
// One generator channel: pending/active config, period and burst counters,
// IDLE/RUN/HOLD state machine with registered outputs.
//
// Config write handshake: cfg_we is a one-cycle valid with no ready; a write
// is always accepted and lands in the pending registers at that edge.
module test_sig_chan
    import test_sig_pkg::*;
#(
    parameter int CNT_W      = 24,
    parameter int BURST_W    = 16,
    parameter int DEF_PERIOD = test_sig_pkg::DEF_PERIOD,
    parameter int DEF_HIGH   = test_sig_pkg::DEF_HIGH
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               en,
    output logic               sig_out,
    output logic               busy,
    output logic               done,
    output chan_state_t        state
);

    logic [CNT_W-1:0]   pend_period, pend_high;
    logic [BURST_W-1:0] pend_burst;
    logic [CNT_W-1:0]   act_period, act_high;
    logic [BURST_W-1:0] act_burst;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] pcnt;
    logic               en_q;

    logic [CNT_W-1:0]   p_eff;
    logic [CNT_W-1:0]   p_last;
    logic [CNT_W-1:0]   cnt_inc;
    logic [BURST_W-1:0] pcnt_nxt;
    logic [BURST_W-1:0] pcnt_sat;
    logic               start;
    logic               boundary;
    logic               burst_end;

    // Effective period, boundary detect and burst-completion detect.
    always_comb begin
        p_eff     = (act_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : act_period;
        p_last    = p_eff - 1'b1;
        cnt_inc   = cnt + 1'b1;
        pcnt_nxt  = pcnt + 1'b1;
        pcnt_sat  = (pcnt == '1) ? pcnt : pcnt_nxt;
        start     = en && !en_q;
        boundary  = (cnt == p_last);
        burst_end = (act_burst != '0) && (pcnt_nxt == act_burst);
    end

    // Channel state machine; new config only takes effect on start or at a period boundary.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            pend_period <= CNT_W'(DEF_PERIOD);
            pend_high   <= CNT_W'(DEF_HIGH);
            pend_burst  <= '0;
            act_period  <= CNT_W'(DEF_PERIOD);
            act_high    <= CNT_W'(DEF_HIGH);
            act_burst   <= '0;
            cnt         <= '0;
            pcnt        <= '0;
            en_q        <= 1'b0;
            sig_out     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            en_q <= en;
            done <= 1'b0;
            // Pending is written after the boundary copy reads it, so a write
            // coinciding with a boundary waits for the next one.
            if (cfg_we) begin
                pend_period <= cfg_period;
                pend_high   <= cfg_high;
                pend_burst  <= cfg_burst;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        act_period <= pend_period;
                        act_high   <= pend_high;
                        act_burst  <= pend_burst;
                        cnt        <= '0;
                        pcnt       <= '0;
                        busy       <= 1'b1;
                        sig_out    <= (pend_high != '0);
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        cnt     <= '0;
                        sig_out <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (boundary) begin
                        act_period <= pend_period;
                        act_high   <= pend_high;
                        act_burst  <= pend_burst;
                        cnt        <= '0;
                        if (burst_end) begin
                            pcnt    <= pcnt_nxt;
                            sig_out <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_HOLD;
                        end else begin
                            pcnt    <= pcnt_sat;
                            sig_out <= (pend_high != '0);
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        sig_out <= (cnt_inc < act_high);
                    end
                end
                ST_HOLD: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    sig_out <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/test_sig_gen.sv
// Multi-channel programmable square-wave / pulse-burst generator.
// The top only decodes cfg_ch into per-channel write strobes; each channel
// is fully independent.
module test_sig_gen
    import test_sig_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CNT_W      = 24,
    parameter int BURST_W    = 16,
    parameter int DEF_PERIOD = test_sig_pkg::DEF_PERIOD,
    parameter int DEF_HIGH   = test_sig_pkg::DEF_HIGH,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [NCH-1:0]     en,
    output logic [NCH-1:0]     sig_out,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     done,
    output logic [2*NCH-1:0]   dbg_state
);

    logic [NCH-1:0] ch_we;

    // Channel select decode; a cfg_ch with no matching channel writes nothing.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        chan_state_t st;

        test_sig_chan #(
            .CNT_W      (CNT_W),
            .BURST_W    (BURST_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_chan (
            .sysclk     (sysclk),
            .rst        (rst),
            .cfg_we     (ch_we[g]),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .cfg_burst  (cfg_burst),
            .en         (en[g]),
            .sig_out    (sig_out[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .state      (st)
        );

        assign dbg_state[2*g +: 2] = st;
    end

endmodule

// File: tb/tb_test_sig_gen.sv
// Self-checking bench for test_sig_gen: per-cycle comparison against a
// waveform-queue reference model, a pattern table and directed sequences.
module tb_test_sig_gen;
    import test_sig_pkg::*;

    localparam int NCH     = 4;
    localparam int CNT_W   = 24;
    localparam int BURST_W = 16;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HOLD  = 2;

    // ---------------- clock / reset / DUT ----------------
    logic               sysclk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [CNT_W-1:0]   cfg_period, cfg_high;
    logic [BURST_W-1:0] cfg_burst;
    logic [NCH-1:0]     en, sig_out, busy, done;
    logic [2*NCH-1:0]   dbg_state;

    // Three-channel instance used to present an out-of-range cfg_ch.
    logic               cfg_we2;
    logic [1:0]         cfg_ch2;
    logic [2:0]         en2, sig2, busy2, done2;
    logic [5:0]         dbg2;

    always #5 sysclk = ~sysclk;

    test_sig_gen #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .sysclk(sysclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_burst(cfg_burst),
        .en(en), .sig_out(sig_out), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    test_sig_gen #(.NCH(3), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut2 (
        .sysclk(sysclk), .rst(rst), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_burst(cfg_burst),
        .en(en2), .sig_out(sig2), .busy(busy2), .done(done2), .dbg_state(dbg2)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each running channel holds a queue with the remaining samples of its
    // current period; the front is what sig_out shows now.
    int m_mode [NCH];
    int m_pp [NCH], m_ph [NCH], m_pb [NCH];
    int m_ap [NCH], m_ah [NCH], m_ab [NCH];
    int m_per [NCH];
    bit m_enp [NCH];
    bit m_done [NCH];
    bit wq [NCH][$];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = M_IDLE;
            m_pp[c] = DEF_PERIOD; m_ph[c] = DEF_HIGH; m_pb[c] = 0;
            m_ap[c] = DEF_PERIOD; m_ah[c] = DEF_HIGH; m_ab[c] = 0;
            m_per[c] = 0; m_enp[c] = 1'b0; m_done[c] = 1'b0;
            wq[c].delete();
        end
    endtask

    task automatic start_period(input int c);
        int p;
        p = (m_ap[c] < 2) ? 2 : m_ap[c];
        wq[c].delete();
        for (int i = 0; i < p; i++) wq[c].push_back(i < m_ah[c]);
    endtask

    task automatic load_active(input int c);
        m_ap[c] = m_pp[c]; m_ah[c] = m_ph[c]; m_ab[c] = m_pb[c];
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            m_done[c] = 1'b0;
            case (m_mode[c])
                M_IDLE: begin
                    if (en[c] && !m_enp[c]) begin
                        load_active(c);
                        m_per[c] = 0;
                        m_mode[c] = M_RUN;
                        start_period(c);
                    end
                end
                M_RUN: begin
                    if (!en[c]) begin
                        m_mode[c] = M_IDLE;
                        wq[c].delete();
                    end else begin
                        void'(wq[c].pop_front());
                        if (wq[c].size() == 0) begin
                            m_per[c]++;
                            if (m_ab[c] != 0 && m_per[c] == m_ab[c]) begin
                                m_mode[c] = M_HOLD;
                                m_done[c] = 1'b1;
                            end else begin
                                load_active(c);
                                start_period(c);
                            end
                        end
                    end
                end
                default: begin
                    if (!en[c]) m_mode[c] = M_IDLE;
                end
            endcase
            m_enp[c] = en[c];
            if (cfg_we && int'(cfg_ch) == c) begin
                m_pp[c] = int'(cfg_period);
                m_ph[c] = int'(cfg_high);
                m_pb[c] = int'(cfg_burst);
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_sig();
        logic [NCH-1:0] e;
        e = '0;
        for (int c = 0; c < NCH; c++) e[c] = (m_mode[c] == M_RUN) ? wq[c][0] : 1'b0;
        return e;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] e;
        e = '0;
        for (int c = 0; c < NCH; c++) e[c] = (m_mode[c] == M_RUN);
        return e;
    endfunction

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] e;
        e = '0;
        for (int c = 0; c < NCH; c++) e[c] = m_done[c];
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    int          cap_ch = 1;
    logic [31:0] cap    = '0;

    // One clock: model advances at the edge, outputs are compared 1 unit later.
    task automatic step();
        @(posedge sysclk);
        model_edge();
        #1;
        check("model_sig", 32'(sig_out), 32'(exp_sig()));
        check("model_busy", 32'(busy), 32'(exp_busy()));
        check("model_done", 32'(done), 32'(exp_done()));
        cap = {cap[30:0], sig_out[cap_ch]};
    endtask

    task automatic cfg_write(input int ch, input int p, input int h, input int b);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_period = CNT_W'(p);
        cfg_high = CNT_W'(h);
        cfg_burst = BURST_W'(b);
        step();
        cfg_we = 1'b0;
    endtask

    // ---------------- pattern table ----------------
    typedef struct {
        int         p;
        int         h;
        logic [7:0] pat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi1, hi2, npulse, ndone, done_at, k;

        tbl[0] = '{8, 3, 8'b1110_0000};
        tbl[1] = '{0, 1, 8'b1010_1010};
        tbl[2] = '{1, 1, 8'b1010_1010};
        tbl[3] = '{8, 0, 8'b0000_0000};
        tbl[4] = '{8, 10, 8'b1111_1111};
        tbl[5] = '{4, 2, 8'b1100_1100};
        tbl[6] = '{3, 1, 8'b1001_0010};

        rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_high = '0; cfg_burst = '0;
        cfg_we2 = 1'b0; cfg_ch2 = '0; en2 = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_sig", 32'(sig_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(dbg_state), 0);
        check("rst_sig2", 32'(sig2), 0);
        @(negedge sysclk);
        rst = 1'b1;
        step(); step();
        check("idle_sig", 32'(sig_out), 0);

        // Default waveform on channel 0: 16000 high then 16000 low
        en[0] = 1'b1;
        hi1 = 0; hi2 = 0;
        for (int i = 0; i < 32000; i++) begin
            step();
            if (i < 16000) hi1 += int'(sig_out[0]);
            else           hi2 += int'(sig_out[0]);
        end
        check("def_high_half", 32'(hi1), 16000);
        check("def_low_half", 32'(hi2), 0);
        step();
        check("def_wrap", 32'(sig_out[0]), 1);
        en[0] = 1'b0;
        step();

        // Pattern table on channel 1
        cap_ch = 1;
        for (int i = 0; i < 7; i++) begin
            cfg_write(1, tbl[i].p, tbl[i].h, 0);
            en[1] = 1'b1;
            cap = '0;
            repeat (8) step();
            check($sformatf("tbl%0d_pat", i), 32'(cap[7:0]), 32'(tbl[i].pat));
            check($sformatf("tbl%0d_busy", i), 32'(busy[1]), 1);
            en[1] = 1'b0;
            step();
            check($sformatf("tbl%0d_stop", i), 32'(sig_out[1]), 0);
        end

        // Config write mid-period: current 8/3 period completes first
        cfg_write(1, 8, 3, 0);
        en[1] = 1'b1;
        cap = '0;
        repeat (3) step();
        cfg_write(1, 4, 2, 0);
        repeat (8) step();
        check("upd_mid", 32'(cap[11:0]), 32'(12'b1110_0000_1100));
        en[1] = 1'b0;
        step();

        // Config write on the boundary cycle: one more 8/3 period first
        cfg_write(1, 8, 3, 0);
        en[1] = 1'b1;
        cap = '0;
        repeat (8) step();
        cfg_write(1, 4, 2, 0);
        repeat (11) step();
        check("upd_bnd", cap[19:0], 32'(20'b1110_0000_1110_0000_1100));
        en[1] = 1'b0;
        step();

        // Burst of 3 on channel 2
        cfg_write(2, 5, 1, 3);
        en[2] = 1'b1;
        npulse = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            npulse += int'(sig_out[2]);
            if (done[2]) begin
                ndone++;
                done_at = i;
            end
        end
        check("burst_pulses", 32'(npulse), 3);
        check("burst_done_n", 32'(ndone), 1);
        check("burst_done_at", 32'(done_at), 15);
        check("burst_busy", 32'(busy[2]), 0);
        npulse = 0;
        repeat (10) begin
            step();
            npulse += int'(sig_out[2]);
        end
        check("hold_quiet", 32'(npulse), 0);
        en[2] = 1'b0;
        step();
        en[2] = 1'b1;
        npulse = 0;
        repeat (20) begin
            step();
            npulse += int'(sig_out[2]);
        end
        check("burst2_pulses", 32'(npulse), 3);
        en[2] = 1'b0;
        step();

        // Out-of-range channel select on the 3-channel instance
        cfg_we2 = 1'b1; cfg_ch2 = 2'd3;
        cfg_period = CNT_W'(2); cfg_high = CNT_W'(1); cfg_burst = '0;
        step();
        cfg_we2 = 1'b0;
        en2 = 3'b111;
        step();
        check("badch_s0", 32'(sig2), 32'(3'b111));
        step();
        check("badch_s1", 32'(sig2), 32'(3'b111));
        en2 = '0;
        step();
        cfg_we2 = 1'b1; cfg_ch2 = 2'd2;
        step();
        cfg_we2 = 1'b0;
        en2 = 3'b111;
        step(); step();
        check("goodch_s1", 32'(sig2), 32'(3'b011));
        en2 = '0;
        step();

        // Abort a burst mid-period on channel 3
        cfg_write(3, 6, 4, 5);
        en[3] = 1'b1;
        repeat (3) step();
        check("abort_pre", 32'(sig_out[3]), 1);
        en[3] = 1'b0;
        ndone = 0;
        step();
        check("abort_sig", 32'(sig_out[3]), 0);
        check("abort_busy", 32'(busy[3]), 0);
        ndone += int'(done[3]);
        repeat (10) begin
            step();
            ndone += int'(done[3]);
        end
        check("abort_nodone", 32'(ndone), 0);

        // Randomized traffic against the model
        en = NCH'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                k = $urandom_range(0, NCH - 1);
                en[k] = ~en[k];
            end
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = 2'($urandom_range(0, 3));
                cfg_period = CNT_W'($urandom_range(0, 12));
                cfg_high = CNT_W'($urandom_range(0, 14));
                cfg_burst = BURST_W'($urandom_range(0, 4));
            end
            step();
            cfg_we = 1'b0;
        end
        en = '0;
        step();

        // Async reset mid-run on all channels
        cfg_write(1, 4, 2, 0);
        en = '1;
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        check("arst_sig", 32'(sig_out), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        model_reset();
        step();
        en = '0;
        @(negedge sysclk);
        rst = 1'b1;
        step();
        en[1] = 1'b1;
        cap = '0;
        repeat (20) step();
        check("arst_default", cap[19:0], 32'(20'hfffff));
        en = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
